nios2_key_debounce: RTL and testbench
=====================================

// Module: nios2_key_debounce
// PURPOSE
//   Conditions raw push-button inputs before the key PIO input port samples them.
//   - Per key: 2-FF synchronizer, then a stability counter.
//   - Output key_clean drives the PIO in_port directly; bounce-free and glitch-free.
//   - Optional one-cycle press/release strobes for interrupt or edge logic.
// PARAMETERS
//   WIDTH            4        number of keys
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles required (10 ms at 50 MHz); legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)   counter width; derived, do not override
// PORTS
//   clk          in   1      system clock
//   reset_n      in   1      reset, synchronous, active-low
//   key_raw      in   WIDTH  asynchronous pad inputs; active-low (0 = pressed)
//   key_clean    out  WIDTH  debounced level, active-low; connects to PIO in_port
//   key_press    out  WIDTH  1-cycle strobe: key_clean[i] went 1->0
//   key_release  out  WIDTH  1-cycle strobe: key_clean[i] went 0->1
// BEHAVIOUR
//   Interface: one clock, clk. Reset reset_n is synchronous and active-low; it is
//   sampled only on the rising edge of clk.
//   Reset values (all registers):
//     sync1, sync2, key_clean = all-ones (released)
//     counters = 0; key_press = key_release = 0
//   Synchronizer: sync1 <= key_raw; sync2 <= sync1. No logic between the two stages.
//   Per-key counter cnt[i], updated every cycle:
//     - sync2[i] == key_clean[i]: cnt <= 0.
//     - sync2[i] != key_clean[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//     - sync2[i] != key_clean[i] and cnt == DEBOUNCE_CYCLES-1: key_clean[i] <= sync2[i]; cnt <= 0.
//   Latency: a clean raw step appears on key_clean DEBOUNCE_CYCLES+2 rising edges after
//   the first edge that samples the new level.
//   Glitch rejection: any return to the old level before terminal count resets cnt to 0,
//   so key_clean never changes. A pulse of DEBOUNCE_CYCLES-1 cycles is always rejected.
//   Strobes are registered and asserted in the same cycle key_clean updates:
//     - key_press[i]   = 1 for exactly one cycle when key_clean[i] goes 1->0.
//     - key_release[i] = 1 for exactly one cycle when key_clean[i] goes 0->1.
//   Key independence: keys share no state. Simultaneous transitions on several keys
//   give simultaneous, independent updates and strobes.
//   Counter bounds: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//   Reset mid-count: the count is discarded and key_clean returns to all-ones the
//   next edge, even if a key is held. A held key then needs a full DEBOUNCE_CYCLES+2
//   cycles to re-assert.
// CONFIGURATION
//   Macro: NIOS2_KEY_DEBOUNCE_EDGE_EN
//   - Defined: key_press and key_release behave as described above.
//   - Undefined: both ports are tied to 0, and the edge registers are not built.
//     key_clean behaviour is identical in both cases.
// STRUCTURE
//   Shared package nios2_key_pkg:
//     - localparam KEY_RELEASED = 1'b1
//     - localparam KEY_DEBOUNCE_DEFAULT = 500000
//     - function clog2 for CNT_W
//   Sub-module nios2_key_debounce_bit (one key: synchronizer, counter, clean register,
//   edge strobes), instantiated WIDTH times in a generate loop.
//   Top level holds no logic beyond the instances and port wiring.
// TESTING  (DEBOUNCE_CYCLES=4 for simulation)
//   T1 Reset: apply reset_n=0 for 2 cycles with key_raw=4'b0000.
//      -> key_clean=4'b1111, strobes 0 during reset.
//      -> key_clean[*]=0 at edge 6 after release (2 + 4).
//   T2 Clean press: key_raw[0] 1->0 held.
//      -> key_clean[0]=0 exactly 6 edges later.
//      -> key_press=4'b0001 for one cycle; key_release stays 0.
//   T3 Bounce: key_raw[1] toggles 0,1,0,1 every cycle, then holds 0.
//      -> key_clean[1] falls 6 edges after the final 1->0.
//      -> Exactly one key_press[1] pulse.
//   T4 Glitch: key_raw[2]=0 for 3 cycles, then 1.
//      -> key_clean stays 4'b1111; no strobes.
//   T5 Simultaneous: key_raw=4'b0000 from all released.
//      -> key_clean=4'b0000 and key_press=4'b1111 in the same cycle.
//      -> Release all: key_release=4'b1111 6 edges later.
//   T6 Mid-count reset: hold key_raw[3]=0 and assert reset_n=0 at count 2.
//      -> key_clean[3]=1 at the next edge.
//      -> After release, key_clean[3]=0 after a full 6 edges.
//   Macro-undefined build: rerun T2.
//      -> key_press and key_release constantly 0; key_clean timing unchanged.

Source files
------------

// File: rtl/nios2_key_pkg.sv
// Shared constants and helpers for the push-button debounce block.
package nios2_key_pkg;

  localparam logic KEY_RELEASED = 1'b1;
  localparam int unsigned KEY_DEBOUNCE_DEFAULT = 500000;

  // Elaboration-time ceil(log2(v)); returns at least 1 so counters are never zero-width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nios2_key_debounce_bit.sv
// One key: 2-FF synchronizer, stability counter, clean level register and optional
// press/release strobes (built only when NIOS2_KEY_DEBOUNCE_EDGE_EN is defined).
module nios2_key_debounce_bit
  import nios2_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_clean,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
      clean_q <= KEY_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronized level agrees with the clean level restarts the count.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CntMax) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign key_clean = clean_q;

`ifdef NIOS2_KEY_DEBOUNCE_EDGE_EN
  logic press_q, release_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= clean_q & ~clean_d;
      release_q <= ~clean_q & clean_d;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
`else
  assign key_press   = 1'b0;
  assign key_release = 1'b0;
`endif

endmodule

// File: rtl/nios2_key_debounce.sv
// Debounces WIDTH active-low push buttons for the key PIO in_port.
// Edge strobes are enabled by defining NIOS2_KEY_DEBOUNCE_EDGE_EN; otherwise tied to 0.
module nios2_key_debounce
  import nios2_key_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_clean,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    nios2_key_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_raw[i]),
      .key_clean  (key_clean[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_nios2_key_debounce.sv
// Scoreboard bench for nios2_key_debounce: directed scenarios plus random key activity,
// checked every cycle against a run-length reference model of the debounce rules.
module tb_nios2_key_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] key_raw = '1;
  logic [W-1:0] key_clean, key_press, key_release;

  nios2_key_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_clean  (key_clean),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the raw level reaches the comparison point two edges after it is
  // sampled; the clean level follows once it has disagreed for D consecutive edges.
  logic [W-1:0] m_pipe1 = '1, m_pipe2 = '1, m_clean = '1;
  int           m_run[W];
  logic         edge_en;

  initial begin
`ifdef NIOS2_KEY_DEBOUNCE_EDGE_EN
    edge_en = 1'b1;
`else
    edge_en = 1'b0;
`endif
    foreach (m_run[i]) m_run[i] = 0;
  end

  task automatic model_edge(input logic [W-1:0] raw, input logic rst_n);
    exp_t e;
    e = '0;
    if (!rst_n) begin
      m_pipe1 = '1;
      m_pipe2 = '1;
      m_clean = '1;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (m_pipe2[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_clean[i] = m_pipe2[i];
            m_run[i]   = 0;
            if (m_clean[i]) e.rel[i] = edge_en;
            else            e.press[i] = edge_en;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pipe2 = m_pipe1;
      m_pipe1 = raw;
    end
    e.clean = m_clean;
    exp_q.push_back(e);
  endtask

  // Drive inputs for the next rising edge and queue what that edge should produce.
  task automatic step(input logic [W-1:0] raw, input logic rst_n);
    @(negedge clk);
    key_raw = raw;
    reset_n = rst_n;
    model_edge(raw, rst_n);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b1);
  endtask

  // Monitor: outputs are sampled shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (key_clean !== e.clean || key_press !== e.press || key_release !== e.rel) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t clean=%b/%b press=%b/%b release=%b/%b (got/exp)",
                   $time, key_clean, e.clean, key_press, e.press, key_release, e.rel);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] raw;
    int           waited;

    // T1: reset with all keys held, then release of reset.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    hold(4'b0000, 8);
    hold(4'b1111, 8);
    // T2: clean press/release on key 0.
    hold(4'b1110, 8);
    hold(4'b1111, 8);
    // T3: bounce on key 1 then hold.
    step(4'b1101, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b1101, 1'b1);
    step(4'b1111, 1'b1);
    hold(4'b1101, 8);
    hold(4'b1111, 8);
    // T4: glitch of D-1 cycles on key 2.
    hold(4'b1011, D - 1);
    hold(4'b1111, 8);
    // T5: simultaneous press and release.
    hold(4'b0000, 8);
    hold(4'b1111, 8);
    // T6: reset mid-count on a held key 3.
    hold(4'b0111, 4);
    step(4'b0111, 1'b0);
    hold(4'b0111, 8);
    hold(4'b1111, 8);

    // Random activity: slow per-key toggling so both rejected and accepted runs occur.
    raw = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 4) == 0) raw[i] = ~raw[i];
      step(raw, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end
    hold(4'b1111, 8);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
